uart_mult_byte_tx: RTL and testbench
====================================

# uart_mult_byte_tx

Multi-byte UART frame transmitter. It is the transmit-side counterpart of the board's multi-byte UART receiver and uses the same frame format: header 0x55, PAYLOAD_NUM payload bytes, CRC-8 over the payload, tail 0xAA. It sits between the command/response logic and the UART TX pin. A single start pulse latches a payload vector, and the block serialises the whole frame 8N1 with no inter-byte gap.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- UART_BPS, 115200: baud rate.
- PAYLOAD_NUM, 11: number of payload bytes. Legal range 1..16.
- BPS_CNT (localparam), CLK_FREQ/UART_BPS: clocks per bit, integer division.
- sys_clk  in  1  system clock. Everything is on its rising edge.
- sys_rst_n  in  1  asynchronous reset, active-low.
- tx_start  in  1  one-cycle request to send a frame.
- tx_payload  in  8*PAYLOAD_NUM  payload. Byte i is tx_payload[8*i+7:8*i]; byte 0 is sent first.
- uart_txd  out  1  serial line, registered. Idle level is high.
- tx_busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse when the tail stop bit has completed.
- tx_byte_cnt  out  8  index of the frame byte currently on the line: 0 = header, PAYLOAD_NUM+1 = CRC, PAYLOAD_NUM+2 = tail.

## Operation
- Reset values: uart_txd=1, tx_busy=0, tx_done=0, tx_byte_cnt=0. The FSM is in IDLE and the CRC register is 0x00.
- Reset mid-frame: uart_txd returns high immediately (asynchronous reset). The partial frame is abandoned and is not resumed.
- FSM states: IDLE, HDR, PAY, CRC, TAIL, DONE.
  - IDLE → HDR on tx_start. HDR → PAY after byte 0 completes.
  - PAY stays in PAY until PAYLOAD_NUM bytes have been sent, then → CRC.
  - CRC → TAIL → DONE, each after one byte completes.
  - DONE → IDLE after one cycle.
- Accepting a request:
  - tx_start is accepted only when tx_busy=0. This includes the DONE cycle.
  - On acceptance, tx_payload is latched into an internal register and the CRC register is cleared to 0x00.
  - tx_start while tx_busy=1 is ignored; no queueing.
  - Input changes after acceptance do not affect the frame in flight.
- Byte serialisation: a 10-bit frame of start bit 0, data bits d0..d7 (LSB first), then stop bit 1. Each bit lasts exactly BPS_CNT clocks, counted by a 16-bit bit-timer.
- CRC-8:
  - Polynomial 0x07, init 0x00, no input/output reflection, no final XOR.
  - Computed over payload bytes only; header and tail are excluded.
  - Updated byte-wise when each payload byte is loaded into the shifter.
  - The CRC byte sent is the register value after the last payload byte.
- tx_byte_cnt updates on the cycle each byte's start bit begins and holds during DONE/IDLE.

## Timing
- Let T be the accepting edge (tx_start=1 with tx_busy=0).
- tx_busy=1 from T+1.
- uart_txd=0 (header start bit) at T+1.
- Bit k of frame byte b (k = 0..9) occupies cycles T+1+(10b+k)·BPS_CNT through T+(10b+k+1)·BPS_CNT.
- Frame length is L = (PAYLOAD_NUM+3)·10·BPS_CNT cycles.
- At T+1+L: tx_done=1 for one cycle, tx_busy=0, and uart_txd=1.
- A tx_start on cycle T+1+L is accepted, and its start bit appears at T+2+L. This gives a minimum idle of 1 cycle between frames.

## Test plan
All scenarios use CLK_FREQ=1000 and UART_BPS=100 (BPS_CNT=10) unless noted.
- Reset and idle: hold sys_rst_n=0, then release with no tx_start → uart_txd=1, tx_busy=0 and tx_done=0 for 1000 cycles.
- Single-byte frame:
  - Stimulus: PAYLOAD_NUM=1, tx_payload=0x01, pulse tx_start.
  - Line decodes to 0x55, 0x01, 0x07, 0xAA.
  - Each bit is 10 cycles; start edge at T+1.
  - tx_done at T+401; tx_busy high from T+1 through T+400.
- Two-byte frame: PAYLOAD_NUM=2, payload {0x02,0x01} with byte0=0x01 → line decodes to 0x55, 0x01, 0x02, 0x1B, 0xAA.
- CRC check value: PAYLOAD_NUM=9, payload ASCII "123456789" → CRC byte 0xF4, then 0xAA.
- Busy and back-to-back behaviour:
  - A tx_start mid-frame with a different payload is ignored; the first frame is unchanged.
  - A tx_start in the tx_done cycle starts a new frame with start bit 1 cycle later.
- Reset mid-frame:
  - Drop sys_rst_n during payload bit 4 → uart_txd=1 and tx_busy=0 asynchronously.
  - After release, a new tx_start sends a complete, correct frame starting with 0x55.

Source files
------------

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART frame transmitter: 0x55, PAYLOAD_NUM payload bytes, CRC-8, 0xAA.
// Each byte goes out 8N1, LSB first, with no gap between bytes.
module uart_mult_byte_tx #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int UART_BPS    = 115200,
  parameter int PAYLOAD_NUM = 11
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     tx_start,
  input  logic [8*PAYLOAD_NUM-1:0] tx_payload,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [7:0]               tx_byte_cnt
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int PI_W    = (PAYLOAD_NUM > 1) ? $clog2(PAYLOAD_NUM) : 1;

  typedef enum logic [2:0] {IDLE, HDR, PAY, CRC, TAIL, DONE} state_t;

  // CRC-8, poly 0x07, MSB first, one whole byte per call
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  state_t                        state;
  logic [PAYLOAD_NUM-1:0][7:0]   pay_q;
  logic [7:0]                    crc_q;
  logic [7:0]                    cur_byte;
  logic [3:0]                    bit_idx;
  logic [15:0]                   bit_tmr;
  logic [PI_W-1:0]               pay_idx;
  logic                          bit_last;

  assign bit_last = (bit_tmr == 16'(BPS_CNT - 1));

  // Frame sequencer, bit timer and line driver in one registered block
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      pay_q       <= '0;
      crc_q       <= 8'h00;
      cur_byte    <= 8'h00;
      bit_idx     <= 4'd0;
      bit_tmr     <= 16'd0;
      pay_idx     <= '0;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_byte_cnt <= 8'd0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE behaves like IDLE for acceptance so frames can run back to back
          if (tx_start) begin
            state       <= HDR;
            pay_q       <= tx_payload;
            crc_q       <= 8'h00;
            cur_byte    <= 8'h55;
            bit_idx     <= 4'd0;
            bit_tmr     <= 16'd0;
            pay_idx     <= '0;
            uart_txd    <= 1'b0;
            tx_busy     <= 1'b1;
            tx_byte_cnt <= 8'd0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (!bit_last) begin
            bit_tmr <= bit_tmr + 16'd1;
          end else if (bit_idx != 4'd9) begin
            // next bit: data bits d0..d7 then the stop bit
            bit_tmr  <= 16'd0;
            bit_idx  <= bit_idx + 4'd1;
            uart_txd <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
          end else begin
            // byte complete: load the next frame byte and drive its start bit
            bit_tmr     <= 16'd0;
            bit_idx     <= 4'd0;
            uart_txd    <= 1'b0;
            tx_byte_cnt <= tx_byte_cnt + 8'd1;
            case (state)
              HDR: begin
                state    <= PAY;
                cur_byte <= pay_q[0];
                crc_q    <= crc8_byte(crc_q, pay_q[0]);
              end
              PAY: begin
                if (pay_idx == PI_W'(PAYLOAD_NUM - 1)) begin
                  state    <= CRC;
                  cur_byte <= crc_q;
                end else begin
                  pay_idx  <= pay_idx + 1'b1;
                  cur_byte <= pay_q[pay_idx + 1'b1];
                  crc_q    <= crc8_byte(crc_q, pay_q[pay_idx + 1'b1]);
                end
              end
              CRC: begin
                state    <= TAIL;
                cur_byte <= 8'hAA;
              end
              TAIL: begin
                state       <= DONE;
                uart_txd    <= 1'b1;
                tx_busy     <= 1'b0;
                tx_done     <= 1'b1;
                tx_byte_cnt <= tx_byte_cnt;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: three instances (1, 2 and 9 payload bytes),
// expected frame bytes queued at stimulus time and compared as the line is decoded.
module tb_uart_mult_byte_tx;
  localparam int B = 10;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start_r [3];
  logic [7:0]  pay1;
  logic [15:0] pay2;
  logic [71:0] pay9;
  logic        txd_w  [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [7:0]  bc_w   [3];

  logic [7:0] exp_q [$];
  int nchk = 0;
  int npass = 0;

  always #5 sys_clk = ~sys_clk;

  uart_mult_byte_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PAYLOAD_NUM(1)) u_d1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_start(start_r[0]), .tx_payload(pay1),
    .uart_txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx_byte_cnt(bc_w[0]));
  uart_mult_byte_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PAYLOAD_NUM(2)) u_d2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_start(start_r[1]), .tx_payload(pay2),
    .uart_txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx_byte_cnt(bc_w[1]));
  uart_mult_byte_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PAYLOAD_NUM(9)) u_d9 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_start(start_r[2]), .tx_payload(pay9),
    .uart_txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx_byte_cnt(bc_w[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // bit-serial reference CRC-8 (poly 0x07, init 0)
  function automatic logic [7:0] m_crc(input logic [127:0] v, input int n);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ v[8*i+b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    return c;
  endfunction

  task automatic push_frame(input logic [127:0] v, input int n);
    exp_q.push_back(8'h55);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
    exp_q.push_back(m_crc(v, n));
    exp_q.push_back(8'hAA);
  endtask

  task automatic set_pay(input int sel, input logic [127:0] v);
    case (sel)
      0: pay1 = v[7:0];
      1: pay2 = v[15:0];
      default: pay9 = v[71:0];
    endcase
  endtask

  // accepting edge falls between the two negedges; returns in the first cycle of the frame
  task automatic pulse(input int sel);
    @(negedge sys_clk); start_r[sel] = 1'b1;
    @(negedge sys_clk); start_r[sel] = 1'b0;
  endtask

  // Decode one frame from the first frame cycle; optional mid-frame request and
  // back-to-back request in the tx_done cycle
  task automatic rx_frame(input int sel, input int nb, input bit inj, input bit chain,
                          input logic [127:0] nxt);
    int j = 0;
    int tgt;
    logic [7:0] byt;
    logic [7:0] e;
    chk("start_edge", 8'(txd_w[sel]), 8'h00);
    chk("busy_start", 8'(busy_w[sel]), 8'h01);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 10; k++) begin
        tgt = (10*b + k)*B + B/2;
        while (j < tgt) begin
          @(negedge sys_clk); j++;
          if (inj && j == 25) begin set_pay(sel, ~nxt); start_r[sel] = 1'b1; end
          if (inj && j == 26) start_r[sel] = 1'b0;
        end
        if (k == 0) begin
          chk("start_bit", 8'(txd_w[sel]), 8'h00);
          chk("byte_cnt", bc_w[sel], 8'(b));
        end else if (k == 9) chk("stop_bit", 8'(txd_w[sel]), 8'h01);
        else byt[k-1] = txd_w[sel];
      end
      if (exp_q.size() == 0) chk("queue_empty", byt, 8'hxx);
      else begin e = exp_q.pop_front(); chk("frame_byte", byt, e); end
    end
    while (j < nb*10*B - 1) begin @(negedge sys_clk); j++; end
    chk("done_early", 8'(done_w[sel]), 8'h00);
    chk("busy_last", 8'(busy_w[sel]), 8'h01);
    @(negedge sys_clk); j++;
    chk("done_pulse", 8'(done_w[sel]), 8'h01);
    chk("busy_done", 8'(busy_w[sel]), 8'h00);
    chk("txd_done", 8'(txd_w[sel]), 8'h01);
    if (chain) begin
      set_pay(sel, nxt);
      push_frame(nxt, nb - 3);
      start_r[sel] = 1'b1;
      @(negedge sys_clk);
      start_r[sel] = 1'b0;
    end else begin
      @(negedge sys_clk);
      chk("done_one_cycle", 8'(done_w[sel]), 8'h00);
      chk("queue_drained", 8'(exp_q.size()), 8'h00);
    end
  endtask

  initial begin
    bit ok;
    logic [127:0] v;
    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    pay1 = '0; pay2 = '0; pay9 = '0;
    repeat (5) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_txd", 8'(txd_w[i]), 8'h01);
      chk("rst_busy", 8'(busy_w[i]), 8'h00);
      chk("rst_done", 8'(done_w[i]), 8'h00);
      chk("rst_cnt", bc_w[i], 8'h00);
    end
    sys_rst_n = 1'b1;
    ok = 1'b1;
    repeat (1000) begin
      @(negedge sys_clk);
      for (int i = 0; i < 3; i++)
        if (txd_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0) ok = 1'b0;
    end
    chk("idle_1000", 8'(ok), 8'h01);

    // single-byte frame: 55 01 07 AA
    v = '0; v[7:0] = 8'h01;
    set_pay(0, v); push_frame(v, 1); pulse(0);
    rx_frame(0, 4, 1'b0, 1'b0, '0);

    // two-byte frame with an ignored mid-frame request, then a back-to-back frame
    v = '0; v[15:0] = 16'h0201;
    set_pay(1, v); push_frame(v, 2); pulse(1);
    rx_frame(1, 5, 1'b1, 1'b1, 128'h3CA5);
    rx_frame(1, 5, 1'b0, 1'b0, '0);

    // check value over "123456789"
    v = '0;
    for (int i = 0; i < 9; i++) v[8*i +: 8] = 8'(8'h31 + i);
    set_pay(2, v); push_frame(v, 9); pulse(2);
    rx_frame(2, 12, 1'b0, 1'b0, '0);

    // reset during payload bit 4, then a clean frame
    v = '0; v[15:0] = 16'h7E81;
    set_pay(1, v); pulse(1);
    repeat ((10 + 4)*B + B/2) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", 8'(txd_w[1]), 8'h01);
    chk("rst_mid_busy", 8'(busy_w[1]), 8'h00);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_mid_idle", 8'(txd_w[1]), 8'h01);
    push_frame(v, 2); pulse(1);
    rx_frame(1, 5, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
